// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 scan-code receiver producing a held-key code
//
// Purpose: receives device-to-host PS/2 frames on the raw pins, checks odd
// parity and the stop bit, and decodes make / break (F0) / extended (E0)
// sequences into a held-key code for the game logic.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      synchronous active-low reset
//   i_ps2_clk    raw PS/2 clock pin (asynchronous)
//   i_ps2_dat    raw PS/2 data pin (asynchronous)
//   o_key        currently held make code, 8'h00 = no key
//   o_key_valid  one-cycle pulse on every accepted make byte
//   o_extended   held key was E0-prefixed
//   o_parity_err one-cycle pulse on a frame failing parity or stop check
//
// Optional feature: PS2_ARROW_ONLY_EN - when defined, only E0-prefixed arrow
// make codes (75, 72, 74, 6B) are accepted; break handling is unaffected.

module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_key,
  output logic       o_key_valid,
  output logic       o_extended,
  output logic       o_parity_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronizers, preset high so reset looks like an idle bus.
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= i_ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= i_ps2_dat;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Clock glitch filter: the filtered level only follows the pin after
  // FILTER_LEN consecutive samples disagree with it.
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Frame FSM
  state_t        state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bitcnt_q;
  logic          par_q;
  logic [TW-1:0] tcnt_q;
  logic          timeout;

  // A fall event in the same cycle as the timeout wins: the frame is alive.
  assign timeout = (state_q != S_IDLE) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) && !fall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fall) begin
      case (state_q)
        S_IDLE:   if (!dat_s2_q) state_d = S_DATA;
        S_DATA:   if (bitcnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      if (fall) begin
        case (state_q)
          S_IDLE:   bitcnt_q <= '0;
          S_DATA: begin
            shift_q  <= {dat_s2_q, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
          end
          S_PARITY: par_q <= dat_s2_q;
          default:  ;
        endcase
      end
      if (fall || timeout || state_q == S_IDLE) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  // FSM outputs: a completed frame is judged on the stop-bit fall event.
  logic frame_end, byte_good, byte_bad;

  always_comb begin
    frame_end = fall && (state_q == S_STOP);
    byte_good = frame_end && (^{shift_q, par_q}) && dat_s2_q;
    byte_bad  = frame_end && !((^{shift_q, par_q}) && dat_s2_q);
  end

  // Byte layer
  logic [7:0] key_q, key_d;
  logic       ext_q, ext_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       extp_q, extp_d;
  logic       brkp_q, brkp_d;
  logic       accept;

  always_comb begin
`ifdef PS2_ARROW_ONLY_EN
    accept = extp_q && (shift_q == 8'h75 || shift_q == 8'h72 ||
                        shift_q == 8'h74 || shift_q == 8'h6B);
`else
    accept = 1'b1;
`endif
  end

  always_comb begin
    key_d   = key_q;
    ext_d   = ext_q;
    valid_d = 1'b0;
    perr_d  = byte_bad;
    extp_d  = extp_q;
    brkp_d  = brkp_q;
    if (byte_bad) begin
      extp_d = 1'b0;
      brkp_d = 1'b0;
    end else if (byte_good) begin
      if (shift_q == 8'hE0) begin
        extp_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brkp_d = 1'b1;
      end else begin
        extp_d = 1'b0;
        brkp_d = 1'b0;
        if (brkp_q) begin
          // Only releasing the key currently shown clears it (last key wins).
          if (shift_q == key_q && extp_q == ext_q) begin
            key_d = 8'h00;
            ext_d = 1'b0;
          end
        end else if (accept) begin
          key_d   = shift_q;
          ext_d   = extp_q;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      key_q   <= 8'h00;
      ext_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      extp_q  <= 1'b0;
      brkp_q  <= 1'b0;
    end else begin
      key_q   <= key_d;
      ext_q   <= ext_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      extp_q  <= extp_d;
      brkp_q  <= brkp_d;
    end
  end

  assign o_key        = key_q;
  assign o_extended   = ext_q;
  assign o_key_valid  = valid_q;
  assign o_parity_err = perr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
`timescale 1ns/1ps

module tb_ps2_key_decoder;

  localparam int HALF = 16;
  localparam int TMO  = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] o_key;
  logic       o_key_valid, o_extended, o_parity_err;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
    .o_key(o_key), .o_key_valid(o_key_valid), .o_extended(o_extended),
    .o_parity_err(o_parity_err)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] key;
    bit         ext;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_key = 8'h00;
  bit m_ext = 0, m_extp = 0, m_brkp = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit is_arrow(logic [7:0] b);
    return b == 8'h75 || b == 8'h72 || b == 8'h74 || b == 8'h6B;
  endfunction

  function automatic void model_byte(logic [7:0] b, bit bad);
    exp_t e;
    bit ok;
    if (bad) begin
      e.is_err = 1; e.key = 8'h00; e.ext = 0;
      exp_q.push_back(e);
      m_extp = 0; m_brkp = 0;
      return;
    end
    if (b == 8'hE0) begin m_extp = 1; return; end
    if (b == 8'hF0) begin m_brkp = 1; return; end
    if (m_brkp) begin
      if (b == m_key && m_extp == m_ext) begin m_key = 8'h00; m_ext = 0; end
    end else begin
`ifdef PS2_ARROW_ONLY_EN
      ok = m_extp && is_arrow(b);
`else
      ok = 1;
`endif
      if (ok) begin
        m_key = b; m_ext = m_extp;
        e.is_err = 0; e.key = b; e.ext = m_extp;
        exp_q.push_back(e);
      end
    end
    m_extp = 0; m_brkp = 0;
  endfunction

  // Monitor: pops an expectation for every pulse the DUT presents.
  always @(negedge clk) begin
    if (rst_n && (o_key_valid || o_parity_err)) begin
      check("pulse_exclusive", {31'd0, o_key_valid & o_parity_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, o_key_valid, o_parity_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, o_parity_err}, {31'd0, e.is_err});
        if (!e.is_err) begin
          check("valid_key", {24'd0, o_key}, {24'd0, e.key});
          check("valid_ext", {31'd0, o_extended}, {31'd0, e.ext});
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(bit d);
    ps2_dat = d;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(logic [7:0] b, bit bad_par, bit bad_stop);
    bit p;
    model_byte(b, bad_par | bad_stop);
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    cyc(HALF + 20);
    check("held_key", {24'd0, o_key}, {24'd0, m_key});
    check("held_ext", {31'd0, o_extended}, {31'd0, m_ext});
  endtask

  task automatic partial(int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_dat = 1'b1;
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] b;
    case ($urandom_range(0, 5))
      0: b = 8'h75;
      1: b = 8'h72;
      2: b = 8'h74;
      3: b = 8'h6B;
      4: b = 8'h1C;
      default: begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
      end
    endcase
    return b;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(5);
    check("rst_key", {24'd0, o_key}, 32'd0);
    check("rst_valid", {31'd0, o_key_valid}, 32'd0);
    check("rst_ext", {31'd0, o_extended}, 32'd0);
    check("rst_perr", {31'd0, o_parity_err}, 32'd0);
    rst_n = 1'b1;
    cyc(20);

    send_byte(8'h1C, 0, 0);
`ifndef PS2_ARROW_ONLY_EN
    check("plan_1c", {24'd0, o_key}, 32'h1C);
`endif
    send_byte(8'hE0, 0, 0);
    send_byte(8'h75, 0, 0);
    check("plan_e075", {23'd0, o_extended, o_key}, 32'h175);
`ifdef PS2_ARROW_ONLY_EN
    send_byte(8'h1C, 0, 0);
    check("arrow_only_1c", {24'd0, o_key}, 32'h75);
`endif
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h75, 0, 0);
    check("plan_release", {23'd0, o_extended, o_key}, 32'h000);
    send_byte(8'h6B, 1, 0);
    check("plan_bad_par", {24'd0, o_key}, 32'h00);
    send_byte(8'hE0, 0, 0);
    send_byte(8'h74, 0, 0);

    // Short clock glitch while idle must be filtered out.
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(40);
    check("glitch_key", {24'd0, o_key}, {24'd0, m_key});

    // Partial frame aborted by timeout; the pending E0 survives it.
    send_byte(8'hE0, 0, 0);
    partial(4);
    cyc(TMO + 1000);
    send_byte(8'h72, 0, 0);
    check("plan_timeout", {24'd0, o_key}, 32'h72);

    // Reset mid-frame after the 5th data bit.
    partial(5);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    m_key = 8'h00; m_ext = 0; m_extp = 0; m_brkp = 0;
    check("midrst_out", {21'd0, o_key, o_key_valid, o_extended, o_parity_err}, 32'd0);
    cyc(40);
    send_byte(8'h1C, 0, 0);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0: send_byte(pick(), 0, 0);
        1: begin send_byte(8'hE0, 0, 0); send_byte(pick(), 0, 0); end
        2: begin
          if (m_ext) send_byte(8'hE0, 0, 0);
          send_byte(8'hF0, 0, 0);
          send_byte(m_key, 0, 0);
        end
        3: begin send_byte(8'hF0, 0, 0); send_byte(pick(), 0, 0); end
        4: send_byte(pick(), 1, 0);
        default: send_byte(pick(), 0, 1);
      endcase
    end

    cyc(50);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames (device-to-host) on raw ps2_clk/ps2_dat pins and decodes scan-code set 2 make, break and extended sequences.
- Drives an 8-bit held-key code that the game logic consumes on its i_key input.
- o_key holds the make code while the key is held and returns to 8'h00 on release; the game FSM's stall loop provides auto-repeat.
- Sits between the board PS/2 connector and the Game block.

Parameters:
- FILTER_LEN, 8: consecutive identical i_clk samples required before the filtered ps2_clk may change level.
- TIMEOUT_CYCLES, 50000: i_clk cycles without a falling edge, mid-frame, before the partial frame is aborted (1 ms at 50 MHz).

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset, synchronous, active-low
- i_ps2_clk  input  1  raw PS/2 clock pin, asynchronous
- i_ps2_dat  input  1  raw PS/2 data pin, asynchronous
- o_key  output  8  currently held make code; 8'h00 = no key
- o_key_valid  output  1  one-cycle pulse on every accepted make byte, including typematic repeats
- o_extended  output  1  1 if the held key was E0-prefixed
- o_parity_err  output  1  one-cycle pulse when a frame fails the parity or stop-bit check

Behaviour:
- Reset (synchronous, active-low, on i_clk): o_key=8'h00, o_key_valid=0, o_extended=0, o_parity_err=0.
  - FSM goes to S_IDLE, shift register is cleared, ext/break flags are cleared, timeout counter = 0.
  - Synchronizer and filtered clock preset to 1 (bus idle).
  - Reset asserted mid-frame discards the partial frame; no output pulse is produced.
- Input path: 2-FF synchronizer on each pin.
  - Filtered clock toggles only after FILTER_LEN consecutive samples differ from its current value.
  - A fall event is a 1->0 transition of the filtered clock. Data is sampled from the synchronized data pin at the fall event.
- FSM states and transitions on fall events:
  - S_IDLE: data==0 (start bit) -> S_DATA, bit count = 0. data==1 -> stay in S_IDLE (glitch ignored).
  - S_DATA: shift in LSB first; after the 8th bit -> S_PARITY.
  - S_PARITY: capture the parity bit -> S_STOP.
  - S_STOP: stop bit sampled, then -> S_IDLE. The frame is good if the XOR of the 8 data bits and the parity bit equals 1 (odd parity) and the stop bit is 1.
- Bad frame: o_parity_err pulses 1 cycle, the byte is discarded, and the ext/break flags are cleared.
- Timeout: the counter increments each cycle while not in S_IDLE and resets on every fall event.
  - Reaching TIMEOUT_CYCLES-1 forces S_IDLE with no output pulse.
  - The ext/break flags are kept.
- Byte layer for a good byte, applied the cycle after the S_STOP fall event (latency 1 cycle):
  - 8'hE0: ext_pending=1; outputs unchanged.
  - 8'hF0: break_pending=1; outputs unchanged.
  - Other byte with break_pending=1:
    - If byte==o_key and ext_pending==o_extended: o_key=8'h00 and o_extended=0.
    - Otherwise outputs are unchanged.
    - Both flags are cleared; no o_key_valid pulse.
  - Other byte with break_pending=0: o_key=byte, o_extended=ext_pending, o_key_valid pulses 1, and both flags are cleared.
- A new make while another key is held replaces o_key (last key wins). Releasing the earlier key does not clear o_key.
- o_key_valid and o_parity_err are never asserted in the same cycle.

Optional Feature:
- Macro: PS2_ARROW_ONLY_EN.
- Defined: a make byte updates o_key and pulses o_key_valid only when it is E0-prefixed and one of 8'h75, 8'h72, 8'h74, 8'h6B. Any other make byte clears the flags and leaves the outputs unchanged. Break handling is unchanged.
- Undefined: every make byte is accepted as described in Behaviour.

Test Plan:
- Frame for byte 8'h1C (start 0, data LSB first, parity 0, stop 1), 12.5 kHz ps2_clk -> o_key=8'h1C, o_extended=0, a single o_key_valid pulse 1 cycle after the stop-bit fall.
- Sequence E0,75 then E0,F0,75 -> o_key=8'h75 with o_extended=1 after the second byte; o_key=8'h00 and o_extended=0 after the final byte.
- Frame 8'h6B with parity bit flipped to 1 -> o_parity_err pulses once, o_key unchanged (8'h00), next good frame 8'h74 decodes normally.
- Start bit, 4 data bits, then clock idles for 60000 cycles -> FSM returns to S_IDLE without pulses; next full frame 8'h72 -> o_key=8'h72.
- 3-cycle low glitch on i_ps2_clk while idle, FILTER_LEN=8 -> no fall event and no state change. Separately, i_rst_n=0 for 1 cycle after the 5th data bit -> all outputs 0, partial frame discarded.
- With PS2_ARROW_ONLY_EN defined: E0,75 -> o_key=8'h75; then 1C -> o_key stays 8'h75 and no o_key_valid pulse.
